// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch unit control, instruction memory and IF/ID bundle
interface instruction_fetch_unit_if;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt;
    logic [31:0] address;
    logic [31:0] instruction;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pcplus4;
    logic        ifid_valid;
    logic        halted;
    logic        misalign_err;

    modport master (
        input  stall, flush, branch_taken, branch_target, halt, instruction,
        output address, ifid_instruction, ifid_pcplus4, ifid_valid, halted, misalign_err
    );

    modport slave (
        output stall, flush, branch_taken, branch_target, halt, instruction,
        input  address, ifid_instruction, ifid_pcplus4, ifid_valid, halted, misalign_err
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC sequencing and IF/ID register; FETCH_ALIGN_CHECK_EN enables branch-target alignment trap
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    instruction_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pcplus4_q, ifid_pcplus4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] pc_plus4;
    logic        target_misaligned;

    assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign target_misaligned = |bus.branch_target[1:0];
    // Sticky: only the RUN-state branch path can raise it, only reset clears it.
    assign misalign_d = misalign_q | ((state_q == RUN) && !bus.halt &&
                                      bus.branch_taken && target_misaligned);
    assign bus.misalign_err = misalign_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) misalign_q <= 1'b0;
        else       misalign_q <= misalign_d;
    end
`else
    logic unused_target_lsbs;

    assign target_misaligned  = 1'b0;
    assign unused_target_lsbs = ^bus.branch_target[1:0];
    assign bus.misalign_err   = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pcplus4_d = ifid_pcplus4_q;
        ifid_valid_d   = ifid_valid_q;
        case (state_q)
            IDLE: begin
                state_d      = RUN;
                ifid_valid_d = 1'b0;
            end
            RUN: begin
                if (bus.halt) begin
                    state_d      = HALTED;
                    ifid_valid_d = 1'b0;
                end else if (bus.branch_taken) begin
                    if (target_misaligned) begin
                        state_d      = HALTED;
                        ifid_valid_d = 1'b0;
                    end else begin
                        // Wrong-path word in IF/ID is squashed to a nop.
                        pc_d         = {bus.branch_target[31:2], 2'b00};
                        ifid_valid_d = 1'b0;
                        ifid_instr_d = '0;
                    end
                end else if (bus.flush) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = '0;
                    if (!bus.stall) pc_d = pc_plus4;
                end else if (!bus.stall) begin
                    ifid_instr_d   = bus.instruction;
                    ifid_pcplus4_d = pc_plus4;
                    ifid_valid_d   = 1'b1;
                    pc_d           = pc_plus4;
                end
            end
            HALTED: begin
                ifid_valid_d = 1'b0;
            end
            default: begin
                state_d      = IDLE;
                ifid_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            ifid_instr_q   <= '0;
            ifid_pcplus4_q <= '0;
            ifid_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pcplus4_q <= ifid_pcplus4_d;
            ifid_valid_q   <= ifid_valid_d;
        end
    end

    assign bus.address          = pc_q;
    assign bus.ifid_instruction = ifid_instr_q;
    assign bus.ifid_pcplus4     = ifid_pcplus4_q;
    assign bus.ifid_valid       = ifid_valid_q;
    assign bus.halted           = (state_q == HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed vectors, corner sequences and randomized model check of instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] salt;
    int          checks = 0;
    int          errors = 0;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a >> 2) * 32'd3) ^ salt;
    endfunction

    assign bus.instruction = mem_word(bus.address);

    // Reference model: 0 = idle, 1 = running, 2 = halted
    int          m_mode;
    logic [31:0] m_pc, m_ins, m_p4;
    logic        m_v, m_err;

    task automatic model_step(input logic r, st, fl, br, input logic [31:0] tgt, input logic hl);
        if (r) begin
            m_mode = 0; m_pc = RESET_PC; m_ins = 0; m_p4 = 0; m_v = 0; m_err = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_v = 0;
        end else if (m_mode == 2) begin
            m_v = 0;
        end else if (hl) begin
            m_mode = 2; m_v = 0;
        end else if (br && ALIGN_CHECK && (tgt % 4 != 0)) begin
            m_err = 1; m_mode = 2; m_v = 0;
        end else if (br) begin
            m_pc = tgt - (tgt % 4); m_v = 0; m_ins = 0;
        end else if (fl) begin
            m_v = 0; m_ins = 0;
            if (!st) m_pc = m_pc + 4;
        end else if (!st) begin
            m_ins = mem_word(m_pc); m_p4 = m_pc + 4; m_v = 1; m_pc = m_pc + 4;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: drive inputs, let one rising edge happen, return at the next negedge.
    task automatic cycle(input logic r, st, fl, br, input logic [31:0] tgt, input logic hl);
        rst = r; bus.stall = st; bus.flush = fl; bus.branch_taken = br;
        bus.branch_target = tgt; bus.halt = hl;
        model_step(r, st, fl, br, tgt, hl);
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        r, st, fl, br;
        logic [31:0] tgt;
        logic        hl;
        logic [31:0] addr, ins, p4;
        logic        v, hd;
    } vec_t;

    function automatic vec_t mk(input logic r, st, fl, br, input logic [31:0] tgt, input logic hl,
                                input logic [31:0] addr, ins, p4, input logic v, hd);
        vec_t x;
        x.r = r; x.st = st; x.fl = fl; x.br = br; x.tgt = tgt; x.hl = hl;
        x.addr = addr; x.ins = ins; x.p4 = p4; x.v = v; x.hd = hd;
        return x;
    endfunction

    vec_t vecs[24];

    initial begin
        logic        exp_hd, exp_err;
        logic [31:0] exp_addr;
        logic        r, st, fl, br, hl;
        logic [31:0] tgt;

        //            rst st fl br target        hl  addr          ins           p4            v  halted
        vecs[0]  = mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h4,        32'h0,        32'h4,        1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h8,        32'h3,        32'h8,        1, 0);
        vecs[4]  = mk(0, 1, 0, 0, 32'h0,        0, 32'h8,        32'h3,        32'h8,        1, 0);
        vecs[5]  = mk(0, 1, 0, 0, 32'h0,        0, 32'h8,        32'h3,        32'h8,        1, 0);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,        0, 32'hC,        32'h6,        32'hC,        1, 0);
        vecs[7]  = mk(0, 1, 0, 1, 32'h40,       0, 32'h40,       32'h0,        32'hC,        0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h44,       32'd48,       32'h44,       1, 0);
        vecs[9]  = mk(0, 0, 0, 1, 32'h10,       0, 32'h10,       32'h0,        32'h44,       0, 0);
        vecs[10] = mk(0, 0, 1, 0, 32'h0,        0, 32'h14,       32'h0,        32'h44,       0, 0);
        vecs[11] = mk(0, 1, 1, 0, 32'h0,        0, 32'h14,       32'h0,        32'h44,       0, 0);
        vecs[12] = mk(0, 0, 0, 0, 32'h0,        0, 32'h18,       32'd15,       32'h18,       1, 0);
        vecs[13] = mk(0, 0, 0, 0, 32'h0,        1, 32'h18,       32'd15,       32'h18,       0, 1);
        vecs[14] = mk(0, 0, 0, 1, 32'h80,       0, 32'h18,       32'd15,       32'h18,       0, 1);
        vecs[15] = mk(0, 1, 1, 1, 32'h80,       1, 32'h18,       32'd15,       32'h18,       0, 1);
        vecs[16] = mk(0, 0, 0, 0, 32'h0,        0, 32'h18,       32'd15,       32'h18,       0, 1);
        vecs[17] = mk(1, 0, 0, 1, 32'h80,       1, RESET_PC,     32'h0,        32'h0,        0, 0);
        vecs[18] = mk(0, 0, 0, 0, 32'h0,        0, RESET_PC,     32'h0,        32'h0,        0, 0);
        vecs[19] = mk(0, 0, 0, 0, 32'h0,        0, 32'h4,        32'h0,        32'h4,        1, 0);
        vecs[20] = mk(1, 1, 0, 0, 32'h0,        0, RESET_PC,     32'h0,        32'h0,        0, 0);
        vecs[21] = mk(0, 0, 0, 0, 32'h0,        0, RESET_PC,     32'h0,        32'h0,        0, 0);
        vecs[22] = mk(0, 0, 0, 1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 0);
        vecs[23] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'hBFFFFFFD, 32'h0,        1, 0);

        salt = 32'h0;
        rst = 1'b1; bus.stall = 0; bus.flush = 0; bus.branch_taken = 0;
        bus.branch_target = 0; bus.halt = 0;
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            cycle(vecs[i].r, vecs[i].st, vecs[i].fl, vecs[i].br, vecs[i].tgt, vecs[i].hl);
            check($sformatf("vec%0d address", i),      bus.address,          vecs[i].addr);
            check($sformatf("vec%0d ifid_instr", i),   bus.ifid_instruction, vecs[i].ins);
            check($sformatf("vec%0d ifid_pcplus4", i), bus.ifid_pcplus4,     vecs[i].p4);
            check($sformatf("vec%0d ifid_valid", i),   {31'b0, bus.ifid_valid}, {31'b0, vecs[i].v});
            check($sformatf("vec%0d halted", i),       {31'b0, bus.halted},  {31'b0, vecs[i].hd});
            check($sformatf("vec%0d misalign", i),     {31'b0, bus.misalign_err}, 32'h0);
        end

        // Misaligned branch target 0x42 taken at PC=4
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("pre_misalign address", bus.address, 32'h4);
        cycle(0, 0, 0, 1, 32'h42, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        exp_addr = 32'h4;  exp_hd = 1'b1; exp_err = 1'b1;
`else
        exp_addr = 32'h40; exp_hd = 1'b0; exp_err = 1'b0;
`endif
        check("misalign address", bus.address, exp_addr);
        check("misalign halted", {31'b0, bus.halted}, {31'b0, exp_hd});
        check("misalign err", {31'b0, bus.misalign_err}, {31'b0, exp_err});
        check("misalign valid", {31'b0, bus.ifid_valid}, 32'h0);
        cycle(0, 0, 0, 1, 32'h80, 0);
        check("misalign sticky err", {31'b0, bus.misalign_err}, {31'b0, exp_err});
        cycle(1, 0, 0, 0, 0, 0);
        check("misalign reset err", {31'b0, bus.misalign_err}, 32'h0);
        check("misalign reset halted", {31'b0, bus.halted}, 32'h0);
        check("misalign reset address", bus.address, RESET_PC);

        // Randomized run against the reference model
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) salt = $urandom;
            r   = ($urandom_range(0, 79) == 0);
            hl  = ($urandom_range(0, 39) == 0);
            br  = ($urandom_range(0, 5) == 0);
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 5) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) tgt[31:4] = 28'hFFFFFFF;
            cycle(r, st, fl, br, tgt, hl);
            check($sformatf("rnd%0d address", n),    bus.address,          m_pc);
            check($sformatf("rnd%0d ifid_instr", n), bus.ifid_instruction, m_ins);
            check($sformatf("rnd%0d ifid_pc4", n),   bus.ifid_pcplus4,     m_p4);
            check($sformatf("rnd%0d ifid_valid", n), {31'b0, bus.ifid_valid}, {31'b0, m_v});
            check($sformatf("rnd%0d halted", n),     {31'b0, bus.halted},  {31'b0, (m_mode == 2)});
            check($sformatf("rnd%0d misalign", n),   {31'b0, bus.misalign_err}, {31'b0, m_err});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, the PC value loaded on reset (word-aligned).
REQ-002 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Stall  input  1  hold PC and IF/ID register.
REQ-005 Flush  input  1  invalidate IF/ID register.
REQ-006 BranchTaken  input  1  redirect PC to BranchTarget.
REQ-007 BranchTarget  input  32  redirect byte address.
REQ-008 Halt  input  1  stop fetching until Reset.
REQ-009 Address  output  32  byte address to the instruction memory (combinational, equals PC).
REQ-010 Instruction  input  32  word returned combinationally by the instruction memory for Address.
REQ-011 IFID_Instruction  output  32  registered fetched word.
REQ-012 IFID_PCPlus4  output  32  registered PC+4 of the fetched word.
REQ-013 IFID_Valid  output  1  IF/ID contents are a real instruction.
REQ-014 Halted  output  1  high while in HALTED state.
REQ-015 MisalignErr  output  1  sticky misaligned-target flag.

Function
REQ-016 FSM states IDLE, RUN, HALTED; the block SHALL move IDLE->RUN unconditionally after exactly one cycle; HALTED is left only via Reset.
REQ-017 In IDLE the block SHALL not fetch: PC held, IFID_Valid=0.
REQ-018 In RUN with no Stall, Flush, BranchTaken or Halt, each edge SHALL capture IFID_Instruction<=Instruction, IFID_PCPlus4<=PC+4, IFID_Valid<=1, PC<=PC+4.
REQ-019 Fetch latency: the word at PC SHALL appear on IFID_Instruction one rising edge after PC is presented on Address.
REQ-020 PC+4 arithmetic SHALL be 32-bit modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-021 BranchTaken in RUN SHALL load PC<={BranchTarget[31:2],2'b00} and clear IFID_Valid and IFID_Instruction (wrong-path word discarded), regardless of Stall or Flush.
REQ-022 Stall in RUN without BranchTaken SHALL hold PC, IFID_Instruction, IFID_PCPlus4 and IFID_Valid.
REQ-023 Flush in RUN without BranchTaken SHALL clear IFID_Valid and IFID_Instruction to 32'h0 (nop); PC SHALL advance by 4 unless Stall is also high, in which case PC holds.
REQ-024 Halt in RUN SHALL take priority over all other inputs except Reset: next state HALTED, PC held, IFID_Valid<=0.
REQ-025 In HALTED, PC and IF/ID contents SHALL hold with IFID_Valid=0; all of Stall, Flush, BranchTaken and Halt are ignored.
REQ-026 Halted SHALL be 1 exactly when the state is HALTED.

Reset
REQ-027 Reset SHALL take priority over every other input in the same cycle.
REQ-028 On Reset: state=IDLE, PC=RESET_PC, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, Halted=0, MisalignErr=0.
REQ-029 Reset asserted mid-operation (including in HALTED or during Stall) SHALL restart fetch from RESET_PC via IDLE.

Configuration
REQ-030 Macro FETCH_ALIGN_CHECK_EN SHALL gate target alignment checking.
REQ-031 With FETCH_ALIGN_CHECK_EN defined: BranchTaken in RUN with BranchTarget[1:0]!=0 SHALL set MisalignErr<=1 (sticky until Reset), enter HALTED, leave PC unchanged and clear IFID_Valid.
REQ-032 Without FETCH_ALIGN_CHECK_EN: BranchTarget[1:0] SHALL be silently ignored per REQ-021 and MisalignErr SHALL be tied to 0.

Verification
REQ-033 Reset, then 4 free-running cycles with memory[i]=i*3 -> Address 0,0,4,8,12; IFID_Instruction 0,3,6,9 with IFID_PCPlus4 4,8,12,16, IFID_Valid rising on the first RUN edge.
REQ-034 Stall high 2 cycles at PC=8 -> Address stays 8, IF/ID holds word at 4 (value 3) with Valid=1; on release, next capture is word 6.
REQ-035 BranchTaken with BranchTarget=32'h40 at PC=12, Stall also high -> next Address 32'h40, IFID_Valid=0, following capture IFID_Instruction=48, IFID_PCPlus4=32'h44.
REQ-036 Flush at PC=16 -> IFID_Valid=0, IFID_Instruction=0, next Address 20; Flush+Stall together -> Address held.
REQ-037 Halt at PC=24, then BranchTaken pulses -> Halted=1, Address stays 24, IFID_Valid=0 indefinitely; Reset -> Address=RESET_PC, Halted=0.
REQ-038 BranchTarget=32'h42 with BranchTaken: with FETCH_ALIGN_CHECK_EN -> MisalignErr=1, Halted=1, PC unchanged; without -> next Address 32'h40, MisalignErr=0.
